// File: rtl/nw_pkg.sv
// rtl/nw_pkg.sv - shared defaults, character codes and loader state type
package nw_pkg;

    localparam int NW_LENGTH = 10;
    localparam int NW_CWIDTH = 2;
    localparam int NW_SWIDTH = 16;

    localparam logic [1:0] NW_A = 2'd0;
    localparam logic [1:0] NW_C = 2'd1;
    localparam logic [1:0] NW_G = 2'd2;
    localparam logic [1:0] NW_T = 2'd3;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nw_load_state_t;

endpackage

// File: rtl/nw_seq_loader.sv
// rtl/nw_seq_loader.sv - serial pair loader, settle timer and score return for the NW grid
module nw_seq_loader
    import nw_pkg::*;
#(
    parameter int LENGTH = NW_LENGTH,
    parameter int CWIDTH = NW_CWIDTH,
    parameter int SWIDTH = NW_SWIDTH,
    parameter int SETTLE = 2 * LENGTH + 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CWIDTH-1:0]          in_a,
    input  logic [CWIDTH-1:0]          in_b,
    output logic [LENGTH*CWIDTH-1:0]   s1,
    output logic [LENGTH*CWIDTH-1:0]   s2,
    output logic                       grid_valid,
    input  logic signed [SWIDTH-1:0]   grid_score,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [SWIDTH-1:0]   out_score,
    output logic                       busy
);

    localparam int IW  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int CNW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] ST_LOAD = LOAD;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]                 state_q, state_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [CNW-1:0]             cnt_q, cnt_d;
    logic [LENGTH*CWIDTH-1:0]   s1_q, s1_d;
    logic [LENGTH*CWIDTH-1:0]   s2_q, s2_d;
    logic                       grid_valid_q, grid_valid_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [SWIDTH-1:0]   out_score_q, out_score_d;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        s1_d         = s1_q;
        s2_d         = s2_q;
        grid_valid_d = grid_valid_q;
        out_valid_d  = out_valid_q;
        out_score_d  = out_score_q;

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    // Decoded write keeps the slot select free of variable part-selects.
                    for (int i = 0; i < LENGTH; i++) begin
                        if (idx_q == IW'(i)) begin
                            s1_d[i*CWIDTH +: CWIDTH] = in_a;
                            s2_d[i*CWIDTH +: CWIDTH] = in_b;
                        end
                    end
                    if (idx_q == IW'(LENGTH - 1)) begin
                        idx_d        = '0;
                        cnt_d        = '0;
                        grid_valid_d = 1'b1;
                        state_d      = ST_RUN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNW'(SETTLE - 1)) begin
                    out_score_d = grid_score;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    grid_valid_d = 1'b0;
                    state_d      = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            idx_q        <= '0;
            cnt_q        <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            grid_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_score_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            grid_valid_q <= grid_valid_d;
            out_valid_q  <= out_valid_d;
            out_score_q  <= out_score_d;
        end
    end

    assign in_ready   = (state_q == ST_LOAD);
    assign busy       = (state_q != ST_LOAD);
    assign s1         = s1_q;
    assign s2         = s2_q;
    assign grid_valid = grid_valid_q;
    assign out_valid  = out_valid_q;
    assign out_score  = out_score_q;

endmodule
